// File: rtl/wb_register_file.sv
// wb_register_file: architectural register file at the write-back boundary.
// Two combinational read ports with a same-cycle write-to-read bypass, a
// hardwired zero register, and a wrapping count of committed writes.
module wb_register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [15:0]           writeCount
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  writeEn;

  // A write commits only when enabled and not aimed at the zero register.
  assign writeEn = RegWrite && (writeReg != ZERO_IDX);

  // Read rule: zero register, then reset, then bypass, then stored value.
  function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    if (idx == ZERO_IDX) begin
      val = '0;
    end else if (!rst_n) begin
      val = '0;
    end else if (RegWrite && (writeReg == idx)) begin
      val = writeData;
    end else begin
      val = regs[idx];
    end
    return val;
  endfunction

  // Register storage; the zero-register entry stays at its reset value forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[writeReg] <= writeData;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeCount <= '0;
    end else if (writeEn) begin
      writeCount <= writeCount + 16'd1;
    end
  end

  // Read port 1, combinational.
  always_comb begin
    readData1 = readPort(readReg1);
  end

  // Read port 2, combinational.
  always_comb begin
    readData2 = readPort(readReg2);
  end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

Architectural register file for the 64-bit pipelined ARM core. It is the receiving end of the write-back stage. The write-back mux output, its destination register number and the `RegWrite` control are committed here on the clock edge. Two combinational read ports feed the decode stage. A same-cycle write-to-read bypass lets decode see a value being written back in the same cycle. Register 31 is the zero register (XZR).

## Interface
Parameters:
- `DATA_WIDTH`, default 64: register width.
- `ADDR_WIDTH`, default 5: register index width; depth is 2^ADDR_WIDTH = 32.
- `ZERO_REG`, default 31: index hardwired to zero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RegWrite`  in  1  write enable from the write-back stage.
- `writeReg`  in  ADDR_WIDTH  destination register index.
- `writeData`  in  DATA_WIDTH  write-back mux result.
- `readReg1`  in  ADDR_WIDTH  read port 1 index.
- `readReg2`  in  ADDR_WIDTH  read port 2 index.
- `readData1`  out  DATA_WIDTH  read port 1 data, combinational.
- `readData2`  out  DATA_WIDTH  read port 2 data, combinational.
- `writeCount`  out  16  count of committed (non-XZR) writes since reset; wraps.

## Operation
**Storage**
- 32 × 64-bit flops, indices 0..31.
- Entry `ZERO_REG` is never written. Its storage may be omitted.

**Write**
- On the rising `clk` edge with `rst_n`=1, `RegWrite`=1 and `writeReg`≠`ZERO_REG`: `regs[writeReg]` ← `writeData`, and `writeCount` increments by 1 (modulo 2^16).
- `RegWrite`=1 with `writeReg`=`ZERO_REG`: no state change, no count increment.

**Read** (each port independent; rules in priority order)
1. Index = `ZERO_REG` → 0.
2. `rst_n`=0 → 0.
3. `RegWrite`=1 and `writeReg` = index → `writeData` (bypass).
4. Otherwise → `regs[index]`.

Both ports may read the same index. Both may bypass in the same cycle.

**Reset**
- While `rst_n`=0, all registers and `writeCount` are held at 0, asynchronously and independent of `clk`.
- Reset asserted mid-operation discards any write on that edge.
- Deassertion is synchronised externally. The first write is accepted on the first rising edge with `rst_n`=1.

## Timing
- Read latency: 0 cycles. Output is combinational from `readRegN`, `RegWrite`, `writeReg`, `writeData` and `rst_n`.
- Write latency: 1 edge. The value is visible from storage after the edge, and via bypass in the same cycle before the edge.
- All outputs are 0 during reset and immediately after reset until the first write.
- No handshake. A write is accepted on every enabled edge, back-to-back, with no stall.
- Two consecutive writes to the same index: the last one wins. Each write increments `writeCount`.
- `writeCount` wraps from 0xFFFF to 0x0000 on the 65536th write.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously, mid-cycle, after registers are loaded. Then read all 32 indices on both ports → every read returns 0 immediately, and `writeCount`=0.
- **Basic write/read:** write X5 ← 0x0123_4567_89AB_CDEF. On the next cycle, with `RegWrite`=0, set `readReg1`=5 and `readReg2`=5 → both ports return 0x0123_4567_89AB_CDEF, and `writeCount`=1.
- **Bypass:**
  - With X7 holding 0x11, drive `RegWrite`=1, `writeReg`=7, `writeData`=0xDEAD_BEEF, `readReg1`=7 → `readData1`=0xDEAD_BEEF before the edge.
  - At the same time, `readReg2`=6 returns X6's stored value.
- **Zero register:** write X31 ← 0xFFFF_FFFF_FFFF_FFFF with `readReg1`=31 → `readData1`=0 in that cycle and the next. `writeCount` is unchanged.
- **Reset during write:** `RegWrite`=1, `writeReg`=3, `writeData`=0x55, with `rst_n` falling before the edge → after release, X3 reads 0 and `writeCount`=0.
- **Counter wrap and full sweep:**
  - Write X0..X30 with value = index × 0x0101_0101_0101_0101, then read each index on both ports → exact values, and `writeCount`=31.
  - Continue to 65536 total writes → `writeCount`=0.
